// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Iterative multiply sequencer that borrows the shared EX-stage ALU to
// compute the low XLEN bits of op_a * op_b by shift-and-add.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   flush               - abandons any operation in progress (highest priority)
//   start_valid/ready   - operand handshake for op_a (multiplicand), op_b (multiplier)
//   res_valid/ready     - result handshake; result = low XLEN bits of product
//   busy                - high while an operation is running or waiting in DONE
//   alu_own             - this block is driving the ALU operands this cycle
//   alu_srca/srcb/ctrl  - ALU operand and control drive (ctrl is always add)
//   alu_result          - combinational ALU output for the current cycle
//
// CNT_W must satisfy 2**CNT_W == XLEN.

module alu_mul_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            start_valid,
   output logic            start_ready,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            alu_own,
   output logic [XLEN-1:0] alu_srca,
   output logic [XLEN-1:0] alu_srcb,
   output logic [2:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;

   logic [XLEN-1:0]   mcand;
   logic [XLEN-1:0]   mplier;
   logic [XLEN-1:0]   acc;
   logic [CNT_W-1:0]  cnt;

   logic              load;
   logic              step;
   logic              last;

   // The iteration being executed now is the last one if no multiplier bits
   // remain above bit 0, or if the full width has been consumed.
   assign last = ((mplier >> 1) == '0) || (cnt == CNT_W'(XLEN - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      step        = 1'b0;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b0;
      alu_own     = 1'b0;
      alu_srca    = '0;
      alu_srcb    = '0;
      alu_ctrl    = 3'b000;
      result      = '0;

      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy     = 1'b1;
            alu_own  = 1'b1;
            alu_srca = acc;
            alu_srcb = mplier[0] ? mcand : '0;
            step     = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            result    = acc;
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Flush wins over any handshake; an operand pair offered alongside it
      // is not captured and must be presented again.
      if (flush) begin
         state_nxt = IDLE;
         load      = 1'b0;
         step      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         cnt <= '0;
      end else if (step) begin
         acc <= alu_result;
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Operand shift registers hold no meaning outside RUN, so they are
   // only written on load or step.
   always_ff @(posedge clk) begin
      if (load) begin
         mcand  <= op_a;
         mplier <= op_b;
      end else if (step) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Testbench for alu_mul_seq: directed cases with literal expectations plus
// randomized operations, all checked cycle by cycle against a transaction
// level model of the multiply timeline.

module tb_alu_mul_seq;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        start_valid;
   logic        start_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] result;
   logic        busy;
   logic        alu_own;
   logic [31:0] alu_srca;
   logic [31:0] alu_srcb;
   logic [2:0]  alu_ctrl;
   logic [31:0] alu_result;

   int n_cmp = 0;
   int n_err = 0;

   alu_mul_seq #(.XLEN(32), .CNT_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .op_b        (op_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .busy        (busy),
      .alu_own     (alu_own),
      .alu_srca    (alu_srca),
      .alu_srcb    (alu_srcb),
      .alu_ctrl    (alu_ctrl),
      .alu_result  (alu_result)
   );

   // Shared ALU stand-in: only the add function is exercised.
   assign alu_result = (alu_ctrl == 3'b000) ? (alu_srca + alu_srcb) : 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Number of iterations for a multiplier: msb index + 1, minimum 1.
   function automatic int n_iter(input logic [31:0] b);
      int n;
      n = 1;
      for (int i = 0; i < 32; i++)
         if (b[i]) n = i + 1;
      return n;
   endfunction

   // ------------------------------------------------------------------
   // Transaction-level model: tracks whether the block is idle, how many
   // iterations remain, and whether a result is waiting.
   // ------------------------------------------------------------------
   bit          m_on   = 1'b0;
   bit          m_idle = 1'b1;
   bit          m_done = 1'b0;
   int          m_run  = 0;
   int          m_n    = 0;
   logic [31:0] m_a, m_b, m_res;

   always @(posedge clk) begin
      if (reset) begin
         m_on = 1'b1; m_idle = 1'b1; m_done = 1'b0; m_run = 0;
      end else if (m_on) begin
         if (flush) begin
            m_idle = 1'b1; m_done = 1'b0; m_run = 0;
         end else if (m_idle && start_valid) begin
            m_idle = 1'b0;
            m_a    = op_a;
            m_b    = op_b;
            m_n    = n_iter(op_b);
            m_run  = m_n;
            m_res  = 32'(64'(op_a) * 64'(op_b));
         end else if (m_run > 0) begin
            m_run--;
            if (m_run == 0) m_done = 1'b1;
         end else if (m_done && res_ready) begin
            m_done = 1'b0; m_idle = 1'b1;
         end
      end
   end

   // Compare process: every cycle after the first reset.
   always @(negedge clk) begin
      if (m_on) begin
         int          k;
         logic [63:0] mask;
         logic [31:0] e_a, e_b;
         chk("start_ready", 32'(start_ready), 32'(m_idle));
         chk("busy",        32'(busy),        32'(!m_idle));
         chk("res_valid",   32'(res_valid),   32'(m_done));
         chk("alu_own",     32'(alu_own),     32'(m_run > 0));
         chk("alu_ctrl",    32'(alu_ctrl),    32'h0);
         e_a = 32'h0;
         e_b = 32'h0;
         if (m_run > 0) begin
            k    = m_n - m_run;
            mask = (64'd1 << k) - 64'd1;
            e_a  = 32'(64'(m_a) * (64'(m_b) & mask));
            e_b  = m_b[k] ? (m_a << k) : 32'h0;
         end
         chk("alu_srca", alu_srca, e_a);
         chk("alu_srcb", alu_srcb, e_b);
         if (m_done) chk("result", result, m_res);
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (start_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("start_ready_timeout", 32'd0, 32'd1);
   endtask

   // One complete operation; hold = cycles of res_ready low in DONE.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit use_lit, input int lit_n,
                         input logic [31:0] lit_r);
      bit ok;
      int k;
      logic [31:0] prod;
      prod = 32'(64'(a) * 64'(b));
      wait_ready(ok);
      if (!ok) return;
      op_a = a; op_b = b; start_valid = 1'b1; res_ready = (hold == 0);
      @(posedge clk);
      #1 start_valid = 1'b0;
      ok = 1'b0;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         chk({nm, "_res_timeout"}, 32'd0, 32'd1);
         return;
      end
      chk({nm, "_latency"}, 32'(k), 32'(n_iter(b) + 1));
      chk({nm, "_result"}, result, prod);
      if (use_lit) begin
         chk({nm, "_latency_lit"}, 32'(k), 32'(lit_n + 1));
         chk({nm, "_result_lit"}, result, lit_r);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk({nm, "_hold_valid"}, 32'(res_valid), 32'd1);
         chk({nm, "_hold_result"}, result, prod);
         chk({nm, "_hold_ready"}, 32'(start_ready), 32'd0);
         chk({nm, "_hold_own"}, 32'(alu_own), 32'd0);
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({nm, "_back_idle"}, 32'(start_ready), 32'd1);
      chk({nm, "_no_valid"}, 32'(res_valid), 32'd0);
   endtask

   initial begin
      bit ok;
      reset = 1'b1; flush = 1'b0; start_valid = 1'b0; res_ready = 1'b1;
      op_a = 32'h0; op_b = 32'h0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_res_valid",   32'(res_valid),   32'd0);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_alu_own",     32'(alu_own),     32'd0);
      chk("rst_result",      result,           32'd0);

      run_op("mul7x6",  32'd7,        32'd6,        0, 1'b1, 3,  32'd42);
      run_op("allones", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b1, 32, 32'h00000001);
      run_op("bzero",   32'h12345678, 32'h0,        0, 1'b1, 1,  32'h0);
      run_op("wrap",    32'h80000000, 32'd2,        0, 1'b1, 2,  32'h0);
      run_op("topbit",  32'd3,        32'h80000000, 0, 1'b1, 32, 32'h80000000);
      run_op("bp5x5",   32'd5,        32'd5,        4, 1'b1, 3,  32'd25);

      // Flush during the second RUN cycle of an 8-iteration operation.
      wait_ready(ok);
      op_a = 32'd1; op_b = 32'hFF; start_valid = 1'b1; res_ready = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_idle",     32'(start_ready), 32'd1);
      chk("flush_no_valid", 32'(res_valid),   32'd0);
      chk("flush_busy",     32'(busy),        32'd0);
      run_op("after_flush", 32'd2, 32'd3, 0, 1'b1, 2, 32'd6);

      // Reset while a result waits in DONE.
      wait_ready(ok);
      op_a = 32'd9; op_b = 32'd9; start_valid = 1'b1; res_ready = 1'b0;
      @(posedge clk);
      #1 start_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("rst_done_timeout", 32'd0, 32'd1);
      chk("done_result_81", result, 32'd81);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rstdone_ready",  32'(start_ready), 32'd1);
      chk("rstdone_valid",  32'(res_valid),   32'd0);
      chk("rstdone_busy",   32'(busy),        32'd0);
      chk("rstdone_result", result,           32'd0);
      res_ready = 1'b1;

      // Flush coincident with start_valid in IDLE: nothing accepted.
      op_a = 32'd4; op_b = 32'd4; start_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 begin start_valid = 1'b0; flush = 1'b0; end
      @(negedge clk);
      chk("flushsv_ready", 32'(start_ready), 32'd1);
      chk("flushsv_busy",  32'(busy),        32'd0);
      chk("flushsv_own",   32'(alu_own),     32'd0);

      // Randomized operations with varying multiplier widths and backpressure.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a, b;
         int sh;
         a  = $urandom;
         sh = $urandom_range(0, 32);
         b  = (sh == 32) ? 32'h0 : ($urandom >> sh);
         run_op("rnd", a, b, $urandom_range(0, 3), 1'b0, 0, 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Iterative 32-bit multiply sequencer that borrows the shared execute-stage ALU to implement a MUL instruction by shift-and-add. It accepts an operand pair over a valid/ready handshake and owns the ALU operand and control inputs while running. It returns the low 32 bits of the product over a second valid/ready handshake. The EX-stage operand mux uses `alu_own` to select between pipeline operands and this block's outputs; the hazard unit stalls the pipeline while `busy` is high.

## Interface
- `XLEN`, 32: operand, result and ALU datapath width.
- `CNT_W`, 5: iteration counter width; must satisfy 2^CNT_W = XLEN.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high; sampled on rising `clk`.
- `flush` input 1: pipeline flush; abandons any operation in progress.
- `start_valid` input 1: operands `op_a`/`op_b` are valid.
- `start_ready` output 1: block can accept operands.
- `op_a` input XLEN: multiplicand.
- `op_b` input XLEN: multiplier.
- `res_valid` output 1: `result` is valid.
- `res_ready` input 1: consumer accepts `result`.
- `result` output XLEN: low XLEN bits of `op_a * op_b`.
- `busy` output 1: high in RUN and DONE.
- `alu_own` output 1: block is driving the ALU this cycle.
- `alu_srca` output XLEN: ALU SrcA when `alu_own`.
- `alu_srcb` output XLEN: ALU SrcB when `alu_own`.
- `alu_ctrl` output 3: ALUControl when `alu_own`; always 3'b000 (add).
- `alu_result` input XLEN: combinational ALU output, same cycle.

## Operation
- There are three states.
  - IDLE: `start_ready`=1. On `start_valid` the block loads `mcand`=`op_a`, `mplier`=`op_b`, `acc`=0, `cnt`=0, then moves to RUN.
  - RUN: `alu_own`=1, `alu_srca`=`acc`, and `alu_srcb`=`mplier[0]` ? `mcand` : 0. Each cycle updates `acc`<=`alu_result`, `mcand`<=`mcand`<<1, `mplier`<=`mplier`>>1, `cnt`<=`cnt`+1. The block moves to DONE when (`mplier`>>1)==0 or `cnt`==XLEN-1.
  - DONE: `res_valid`=1 and `result`=`acc`, both held stable until `res_ready`=1. On that handshake the block returns to IDLE.
- All arithmetic is modulo 2^XLEN; carries out of bit XLEN-1 are discarded. Signed and unsigned operands give identical results, so there is no sign handling.
- Early termination: the iteration count equals the index of the highest set bit of `op_b` plus 1, with a minimum of 1. `op_b`=0 takes 1 RUN cycle and adds 0.
- `flush` forces the next state to IDLE from any state and has priority over `start_valid` and `res_ready`. A result in DONE is dropped without a handshake.
- When `alu_own`=0, `alu_srca`/`alu_srcb` are driven 0 and `alu_ctrl` is 3'b000.
- `start_ready` depends only on state, never combinationally on `start_valid`.

## Timing
- Reset values (cycle after `reset` is high at an edge): state IDLE, `start_ready`=1, `res_valid`=0, `busy`=0, `alu_own`=0, `result`=0, `acc`=0, `cnt`=0. Reset high mid-RUN or mid-DONE aborts and drops the result.
- Accept happens at edge T0 with `start_valid`·`start_ready`. RUN occupies cycles T0+1 .. T0+N, where N = max(1, msb_index(`op_b`)+1) and 1 ≤ N ≤ XLEN. `res_valid` rises in cycle T0+N+1.
- Minimum turnaround from accept to next accept is N+2 cycles when `res_ready` is held high: RUN×N, DONE×1, IDLE×1.
- There is no combinational path from `start_valid` or `res_ready` to any output. The only combinational path is `alu_result` → `acc` D-input.
- `start_valid` in the same cycle as `flush` is ignored and must be re-presented.

## Test plan
- Reset, then `op_a`=7, `op_b`=6, `res_ready`=1 → N=3 RUN cycles, `res_valid` at T0+4 with `result`=42, then `start_ready` back to 1.
- `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF → N=32, `result`=0x00000001; `op_a`=0x12345678, `op_b`=0 → N=1, `result`=0.
- `op_a`=0x80000000, `op_b`=2 → `result`=0 (wrap); `op_a`=3, `op_b`=0x80000000 → N=32, `result`=0x80000000.
- Backpressure: `op_a`=5, `op_b`=5, `res_ready` low for 4 cycles → `res_valid` and `result`=25 held stable, `start_ready`=0, `alu_own`=0 throughout DONE.
- `flush` in RUN cycle 2 of `op_b`=0xFF → IDLE next cycle, no `res_valid`. A following `op_a`=2, `op_b`=3 then yields 6.
- `reset` in DONE, and `flush` coincident with `start_valid` in IDLE → both return to reset values and no operation is accepted.
